mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit for the execute stage of the five-stage pipeline. It takes forwarded rs/rt operands and a decoded operation from the E-stage controller, and holds the architectural HI/LO registers. It raises `busy` while an operation is in flight, and the hazard unit stalls any md/mf/mt instruction in D on `start | busy`. HI/LO outputs feed the E→M pipeline register for mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu (≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu (≥1).
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `op`  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- `start`  input  1  high in the cycle a mult/multu/div/divu is in E; qualifies ops 1–4 only.
- `src_a`  input  32  forwarded rs value.
- `src_b`  input  32  forwarded rt value.
- `busy`  output  1  operation in flight.
- `hi`  output  32  architectural HI.
- `lo`  output  32  architectural LO.

## Operation
- State: `hi`, `lo`, a down-counter `cnt` (width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)+1)), a pending-result pair `res_hi`/`res_lo`, and a `div_zero` flag.
- `busy` = (`cnt` != 0); `busy` is registered-state derived, with no combinational path from `start`.
- Start of an operation, when `start`=1, op ∈ {1..4} and `busy`=0:
  - The result is computed from `src_a`/`src_b` as sampled on that edge and latched into `res_hi`/`res_lo`.
  - `cnt` is loaded with MULT_CYCLES or DIV_CYCLES.
- Results:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: lo = unsigned quotient; hi = unsigned remainder.
  - Divide by zero (div/divu with src_b=0): runs the full DIV_CYCLES with `busy` high, then leaves hi/lo unchanged.
- Completion: on the edge where `cnt` goes 1→0, hi/lo ← res_hi/res_lo, except in the divide-by-zero case.
- `start` while `busy`=1 is ignored; there is no queueing and the in-flight op is unaffected.
- `start`=1 with op ∉ {1..4} is ignored.
- mthi/mtlo: when op=7/8 and `busy`=0, hi/lo ← `src_a` on the edge. They are ignored while `busy`=1, since the pipeline never issues them then.
- mfhi/mflo (op 5/6) have no side effect; the consumer reads `hi`/`lo` directly.
- Reset (synchronous, any cycle, including mid-operation) sets hi=0, lo=0, cnt=0, busy=0, and discards the pending result. Reset has priority over all other inputs.

## Timing
- Start edge at end of cycle t: `busy`=1 in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo show the new value and `busy`=0 from cycle t+N+1.
- Back-to-back: a new `start` is accepted in cycle t+N+1 (first cycle `busy`=0).
- hi/lo are stable, holding their old values, during cycles t+1 … t+N; mfhi stalled by hazard logic sees the new value after release.
- mthi/mtlo: value visible on `hi`/`lo` the cycle after the write edge.
- Simultaneous completion edge and mthi/mtlo: cannot be accepted because `busy`=1 that cycle; the completion write wins.
- Outputs after reset: busy=0, hi=0, lo=0.

## Test plan
- Reset, then mult with src_a=0xFFFFFFFE (−2), src_b=3, start=1 for 1 cycle → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with src_a=0xFFFFFFFF, src_b=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div with src_a=0xFFFFFFF9 (−7), src_b=2 → busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu with src_a=7, src_b=0 after mthi 0x1234 and mtlo 0x5678 → busy for 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- mult 6×7 started, second start (div 100/3) pulsed at busy cycle 2, reset asserted at busy cycle 4 → the div is ignored, reset gives busy=0, hi=lo=0, and no later write occurs.
- mult 6×7, then div 100/3 started in the first cycle `busy`=0 → lo=42, hi=0 at that point; after 10 more busy cycles lo=33, hi=1.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the execute stage.
// Owns the architectural HI/LO registers.
//
// Ports:
//   clk    - clock; all state changes on its rising edge
//   reset  - synchronous, active-high reset
//   op     - E-stage operation code (1 mult, 2 multu, 3 div, 4 divu,
//            5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none)
//   start  - qualifies ops 1..4 in the cycle they are in E
//   src_a  - forwarded rs value
//   src_b  - forwarded rt value
//   busy   - operation in flight (registered)
//   hi     - architectural HI
//   lo     - architectural LO
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      res_hi, res_hi_n, res_lo, res_lo_n;
  logic [31:0]      hi_n, lo_n;
  logic             div_zero, div_zero_n;
  logic             active;

  // Arithmetic datapath, evaluated on the current operands.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, safe_b, safe_abs_b;
  logic [31:0] uq_u, ur_u, uq_s, ur_s, q_s, r_s;

  always_comb begin
    // Sign-extended 64-bit operands: the low 64 bits of the product are the signed result.
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};

    // A zero divisor is replaced by 1 so no X reaches the pending result; it is never committed.
    safe_b = (src_b == 32'd0) ? 32'd1 : src_b;
    uq_u   = src_a / safe_b;
    ur_u   = src_a % safe_b;

    // Signed divide on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 r 0.
    a_neg      = src_a[31];
    b_neg      = src_b[31];
    abs_a      = a_neg ? (32'd0 - src_a) : src_a;
    abs_b      = b_neg ? (32'd0 - src_b) : src_b;
    safe_abs_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq_s       = abs_a / safe_abs_b;
    ur_s       = abs_a % safe_abs_b;
    q_s        = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
    r_s        = a_neg ? (32'd0 - ur_s) : ur_s;
  end

  // Next-state logic: completion, new start, or mthi/mtlo.
  always_comb begin
    cnt_n      = cnt;
    hi_n       = hi;
    lo_n       = lo;
    res_hi_n   = res_hi;
    res_lo_n   = res_lo;
    div_zero_n = div_zero;
    active     = (cnt != '0);

    if (active) begin
      cnt_n = cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && !div_zero) begin
        hi_n = res_hi;
        lo_n = res_lo;
      end
    end else if (start && (op >= OP_MULT) && (op <= OP_DIVU)) begin
      div_zero_n = 1'b0;
      case (op)
        OP_MULT: begin
          cnt_n    = CNT_W'(MULT_CYCLES);
          res_hi_n = prod_s[63:32];
          res_lo_n = prod_s[31:0];
        end
        OP_MULTU: begin
          cnt_n    = CNT_W'(MULT_CYCLES);
          res_hi_n = prod_u[63:32];
          res_lo_n = prod_u[31:0];
        end
        OP_DIV: begin
          cnt_n      = CNT_W'(DIV_CYCLES);
          res_hi_n   = r_s;
          res_lo_n   = q_s;
          div_zero_n = (src_b == 32'd0);
        end
        default: begin
          cnt_n      = CNT_W'(DIV_CYCLES);
          res_hi_n   = ur_u;
          res_lo_n   = uq_u;
          div_zero_n = (src_b == 32'd0);
        end
      endcase
    end else if (op == OP_MTHI) begin
      hi_n = src_a;
    end else if (op == OP_MTLO) begin
      lo_n = src_a;
    end
  end

  // State register; busy is registered alongside cnt and always equals (cnt != 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      busy     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      busy     <= (cnt_n != '0);
      hi       <= hi_n;
      lo       <= lo_n;
      res_hi   <= res_hi_n;
      res_lo   <= res_lo_n;
      div_zero <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a table of directed vectors plus
// hand-written sequences for abort-by-reset, back-to-back and mthi-while-busy.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .start (start),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for one cycle, then count busy cycles while checking hi/lo hold.
  task automatic run_op(input logic [3:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int n, output logic held);
    logic [31:0] old_hi, old_lo;
    old_hi = hi;
    old_lo = lo;
    op = o; start = s; src_a = a; src_b = b;
    step();
    op = 4'd0; start = 1'b0;
    n = 0;
    held = 1'b1;
    while (busy && n < 200) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      n++;
      step();
    end
  endtask

  initial begin
    int  n;
    logic held;
    logic ok;

    vecs[0]  = '{"mult_neg2x3",     4'd1, 1'b1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",       4'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_neg7_2",      4'd3, 1'b1, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"mthi",            4'd7, 1'b0, 32'h00001234, 32'd0,        0,  32'h00001234, 32'hFFFFFFFD};
    vecs[4]  = '{"mtlo",            4'd8, 1'b0, 32'h00005678, 32'd0,        0,  32'h00001234, 32'h00005678};
    vecs[5]  = '{"divu_by_zero",    4'd4, 1'b1, 32'd7,        32'd0,        10, 32'h00001234, 32'h00005678};
    vecs[6]  = '{"div_overflow",    4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[7]  = '{"divu_max_16",     4'd4, 1'b1, 32'hFFFFFFFF, 32'd16,       10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{"div_7_neg2",      4'd3, 1'b1, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"mult_minxmin",    4'd1, 1'b1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[10] = '{"start_bad_op",    4'd9, 1'b1, 32'h11111111, 32'h22222222, 0,  32'h40000000, 32'h00000000};
    vecs[11] = '{"mfhi_no_effect",  4'd5, 1'b0, 32'h33333333, 32'h44444444, 0,  32'h40000000, 32'h00000000};
    vecs[12] = '{"mult_no_start",   4'd1, 1'b0, 32'd5,        32'd5,        0,  32'h40000000, 32'h00000000};

    reset = 1'b1; op = 4'd0; start = 1'b0; src_a = 32'd0; src_b = 32'd0;
    step();
    step();
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].start, vecs[i].a, vecs[i].b, n, held);
      check({vecs[i].name, "_busy_cycles"}, 32'(n), 32'(vecs[i].exp_busy));
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      if (vecs[i].exp_busy > 0) check({vecs[i].name, "_hold"}, 32'(held), 32'd1);
    end

    // Abort: mult 6x7, ignored div start at busy cycle 2, reset at busy cycle 4.
    op = 4'd1; start = 1'b1; src_a = 32'd6; src_b = 32'd7;
    step();                                   // busy cycle 1
    op = 4'd0; start = 1'b0;
    step();                                   // busy cycle 2
    op = 4'd3; start = 1'b1; src_a = 32'd100; src_b = 32'd3;
    step();                                   // busy cycle 3
    op = 4'd0; start = 1'b0;
    check("abort_busy_c3", 32'(busy), 32'd1);
    step();                                   // busy cycle 4
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    check("abort_no_late_write", 32'(ok), 32'd1);

    // Back-to-back: div accepted in the first non-busy cycle after mult.
    op = 4'd1; start = 1'b1; src_a = 32'd6; src_b = 32'd7;
    step();
    op = 4'd0; start = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    check("b2b_mult_cycles", 32'(n), 32'd5);
    check("b2b_mult_lo", lo, 32'd42);
    check("b2b_mult_hi", hi, 32'd0);
    run_op(4'd3, 1'b1, 32'd100, 32'd3, n, held);
    check("b2b_div_cycles", 32'(n), 32'd10);
    check("b2b_div_lo", lo, 32'd33);
    check("b2b_div_hi", hi, 32'd1);

    // mthi/mtlo presented throughout a mult (including completion edge) are ignored.
    op = 4'd1; start = 1'b1; src_a = 32'd2; src_b = 32'd3;
    step();
    start = 1'b0;
    n = 0;
    ok = 1'b1;
    while (busy && n < 200) begin
      op = (n % 2 == 0) ? 4'd7 : 4'd8;
      src_a = 32'hDEADBEEF;
      if (hi !== 32'd1 || lo !== 32'd33) ok = 1'b0;
      n++;
      step();
    end
    op = 4'd0;
    check("mt_busy_cycles", 32'(n), 32'd5);
    check("mt_busy_hold", 32'(ok), 32'd1);
    check("mt_busy_hi", hi, 32'd0);
    check("mt_busy_lo", lo, 32'd6);

    // mthi accepted once idle, visible the next cycle.
    op = 4'd7; src_a = 32'hCAFEF00D;
    step();
    op = 4'd0;
    check("mthi_idle", hi, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
